// File: rtl/keypad_entry.sv
// keypad_entry: account/PIN keypad front end feeding the ATM auth stage.
// Optional lockout after repeated auth failures: define KEYPAD_LOCKOUT_EN.
module keypad_entry #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
   parameter logic [1:0]  MAX_TRIES      = 2'd3,
   parameter logic [15:0] LOCK_CYCLES    = 16'd5000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        auth_done,
   input  logic        auth_ok,
   input  logic        session_end,
   output logic [11:0] account_num,
   output logic [13:0] pin,
   output logic        cred_valid,
   output logic        session_active,
   output logic        error,
   output logic        locked
);

   typedef enum logic [2:0] {
      ST_ACCT,
      ST_PIN,
      ST_WAIT_AUTH,
      ST_SESSION
`ifdef KEYPAD_LOCKOUT_EN
      , ST_LOCKED
`endif
   } state_t;

   state_t      state;
   logic [13:0] acc;
   logic [2:0]  digit_cnt;
   logic [1:0]  try_cnt;
   logic [15:0] tmr;

   logic        is_digit;
   logic        is_enter;
   logic        is_clear;
   logic [13:0] acc_next;
   logic [1:0]  try_inc;
   logic        in_lock;
   logic        timing;
   logic [15:0] tmr_lim;
   logic        tmr_hit;
   logic        full;

   assign is_digit = (key_code <= 4'd9);
   assign is_enter = (key_code == 4'hA);
   assign is_clear = (key_code == 4'hB);
   assign acc_next = (acc * 14'd10) + {10'd0, key_code};
   assign full     = (digit_cnt == 3'd4);

   assign try_inc = (try_cnt == MAX_TRIES) ? MAX_TRIES
                                           : try_cnt + 2'd1;

`ifdef KEYPAD_LOCKOUT_EN
   assign in_lock = (state == ST_LOCKED);
`else
   assign in_lock = 1'b0;
`endif

   // One timer serves both the idle timeout and the lockout hold.
   assign timing  = ((state == ST_ACCT) && (digit_cnt != 3'd0))
                 || (state == ST_PIN);
   assign tmr_lim = in_lock ? LOCK_CYCLES : TIMEOUT_CYCLES;
   assign tmr_hit = (tmr == tmr_lim - 16'd1);

   // Entry FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_ACCT;
         acc            <= '0;
         digit_cnt      <= '0;
         try_cnt        <= '0;
         tmr            <= '0;
         account_num    <= '0;
         pin            <= '0;
         cred_valid     <= 1'b0;
         session_active <= 1'b0;
         error          <= 1'b0;
         locked         <= 1'b0;
      end else if (session_end && !in_lock) begin
         state          <= ST_ACCT;
         acc            <= '0;
         digit_cnt      <= '0;
         tmr            <= '0;
         account_num    <= '0;
         pin            <= '0;
         cred_valid     <= 1'b0;
         session_active <= 1'b0;
         error          <= 1'b0;
      end else begin
         error <= 1'b0;
         case (state)
            ST_ACCT, ST_PIN: begin
               if (key_valid) begin
                  tmr <= '0;
                  unique case (1'b1)
                     is_digit: begin
                        if (full) begin
                           error <= 1'b1;
                        end else begin
                           acc       <= acc_next;
                           digit_cnt <= digit_cnt + 3'd1;
                        end
                     end
                     is_clear: begin
                        acc       <= '0;
                        digit_cnt <= '0;
                     end
                     is_enter: begin
                        acc       <= '0;
                        digit_cnt <= '0;
                        if (state == ST_ACCT) begin
                           if (full && (acc <= 14'd4095)) begin
                              account_num <= acc[11:0];
                              state       <= ST_PIN;
                           end else begin
                              error <= 1'b1;
                           end
                        end else begin
                           if (full) begin
                              pin        <= acc;
                              cred_valid <= 1'b1;
                              state      <= ST_WAIT_AUTH;
                           end else begin
                              error <= 1'b1;
                           end
                        end
                     end
                     default: error <= 1'b1;
                  endcase
               end else if (timing && tmr_hit) begin
                  error       <= 1'b1;
                  acc         <= '0;
                  digit_cnt   <= '0;
                  tmr         <= '0;
                  account_num <= '0;
                  state       <= ST_ACCT;
               end else if (timing) begin
                  tmr <= tmr + 16'd1;
               end else begin
                  tmr <= '0;
               end
            end
            ST_WAIT_AUTH: begin
               tmr <= '0;
               if (auth_done) begin
                  cred_valid <= 1'b0;
                  if (auth_ok) begin
                     try_cnt        <= '0;
                     session_active <= 1'b1;
                     state          <= ST_SESSION;
                  end else begin
                     error       <= 1'b1;
                     try_cnt     <= try_inc;
                     account_num <= '0;
                     pin         <= '0;
                     state       <= ST_ACCT;
`ifdef KEYPAD_LOCKOUT_EN
                     if (try_inc == MAX_TRIES) begin
                        locked <= 1'b1;
                        state  <= ST_LOCKED;
                     end
`endif
                  end
               end
            end
            ST_SESSION: begin
               tmr <= '0;
            end
`ifdef KEYPAD_LOCKOUT_EN
            ST_LOCKED: begin
               if (tmr_hit) begin
                  tmr     <= '0;
                  locked  <= 1'b0;
                  try_cnt <= '0;
                  state   <= ST_ACCT;
               end else begin
                  tmr <= tmr + 16'd1;
               end
            end
`endif
            default: begin
               state <= ST_ACCT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: scoreboard bench for keypad_entry.
// Credentials queued at PIN entry are checked when cred_valid rises.
module tb_keypad_entry;

   logic        clk = 1'b0;
   logic        reset;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        auth_done;
   logic        auth_ok;
   logic        session_end;
   logic [11:0] account_num;
   logic [13:0] pin;
   logic        cred_valid;
   logic        session_active;
   logic        error;
   logic        locked;

   int checks = 0;
   int errors = 0;
   int err_seen = 0;
   int e0;

   typedef struct {
      logic [11:0] acct;
      logic [13:0] pin;
   } cred_t;

   cred_t exp_q[$];
   cred_t exp_c;
   logic  cred_q = 1'b0;

   always #5 clk = ~clk;

   keypad_entry dut (
      .clk            (clk),
      .reset          (reset),
      .key_valid      (key_valid),
      .key_code       (key_code),
      .auth_done      (auth_done),
      .auth_ok        (auth_ok),
      .session_end    (session_end),
      .account_num    (account_num),
      .pin            (pin),
      .cred_valid     (cred_valid),
      .session_active (session_active),
      .error          (error),
      .locked         (locked)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // Monitor: count error pulses, score credentials on cred_valid rise.
   always @(negedge clk) begin
      if (!reset) begin
         if (error) err_seen++;
         if (cred_valid && !cred_q) begin
            if (exp_q.size() == 0) begin
               chk("cred_unexp", 32'd1, 32'd0);
            end else begin
               exp_c = exp_q.pop_front();
               chk("cred_acct", 32'(account_num), 32'(exp_c.acct));
               chk("cred_pin", 32'(pin), 32'(exp_c.pin));
            end
         end
      end
      cred_q <= cred_valid;
   end

   task automatic press(input logic [3:0] k);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic enter4(input int v);
      press(4'((v / 1000) % 10));
      press(4'((v / 100) % 10));
      press(4'((v / 10) % 10));
      press(4'(v % 10));
      press(4'hA);
   endtask

   task automatic creds(input int a, input int p);
      enter4(a);
      exp_q.push_back(cred_t'{12'(a), 14'(p)});
      enter4(p);
   endtask

   task automatic auth(input logic ok);
      @(negedge clk);
      auth_done = 1'b1;
      auth_ok   = ok;
      @(negedge clk);
      auth_done = 1'b0;
      auth_ok   = 1'b0;
   endtask

   task automatic end_sess();
      @(negedge clk);
      session_end = 1'b1;
      @(negedge clk);
      session_end = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got 0 exp 1");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      key_valid   = 1'b0;
      key_code    = 4'd0;
      auth_done   = 1'b0;
      auth_ok     = 1'b0;
      session_end = 1'b0;
      idle(3);
      chk("rst_acct", 32'(account_num), 0);
      chk("rst_pin", 32'(pin), 0);
      chk("rst_cred", 32'(cred_valid), 0);
      chk("rst_sess", 32'(session_active), 0);
      chk("rst_err", 32'(error), 0);
      chk("rst_lock", 32'(locked), 0);
      reset = 1'b0;
      idle(2);

      // Full login and session.
      e0 = err_seen;
      creds(2749, 1);
      chk("login_cred", 32'(cred_valid), 1);
      chk("login_acct", 32'(account_num), 2749);
      chk("login_pin", 32'(pin), 1);
      press(4'd5);
      chk("wait_hold", 32'(cred_valid), 1);
      auth(1'b1);
      chk("sess_on", 32'(session_active), 1);
      chk("sess_cred", 32'(cred_valid), 0);
      press(4'd3);
      chk("sess_keys", 32'(session_active), 1);
      end_sess();
      chk("sess_off", 32'(session_active), 0);
      chk("end_acct", 32'(account_num), 0);
      chk("end_pin", 32'(pin), 0);
      idle(2);
      chk("login_errs", 32'(err_seen - e0), 0);

      // Account out of range.
      e0 = err_seen;
      enter4(5000);
      idle(2);
      chk("range_err", 32'(err_seen - e0), 1);
      chk("range_acct", 32'(account_num), 0);
      enter4(1234);
      chk("range_retry", 32'(account_num), 1234);
      end_sess();

      // CLEAR mid entry.
      e0 = err_seen;
      press(4'd1);
      press(4'd2);
      press(4'hB);
      press(4'd3);
      press(4'd0);
      press(4'd0);
      press(4'd0);
      press(4'hA);
      idle(2);
      chk("clr_errs", 32'(err_seen - e0), 0);
      chk("clr_acct", 32'(account_num), 3000);
      end_sess();

      // Idle timeout after one digit.
      press(4'd4);
      idle(999);
      chk("to_early", 32'(error), 0);
      idle(1);
      chk("to_pulse", 32'(error), 1);
      idle(1);
      chk("to_single", 32'(error), 0);
      enter4(1234);
      chk("to_cleared", 32'(account_num), 1234);
      end_sess();

      // session_end beats a simultaneous digit.
      press(4'd1);
      press(4'd2);
      @(negedge clk);
      key_valid   = 1'b1;
      key_code    = 4'd7;
      session_end = 1'b1;
      @(negedge clk);
      key_valid   = 1'b0;
      session_end = 1'b0;
      e0 = err_seen;
      enter4(1234);
      idle(2);
      chk("se_errs", 32'(err_seen - e0), 0);
      chk("se_acct", 32'(account_num), 1234);
      end_sess();

      // Illegal key and fifth digit are rejected.
      e0 = err_seen;
      press(4'd1);
      press(4'd2);
      press(4'hF);
      press(4'd3);
      press(4'd4);
      press(4'd5);
      press(4'hA);
      idle(2);
      chk("ill_errs", 32'(err_seen - e0), 2);
      chk("ill_acct", 32'(account_num), 1234);
      end_sess();

      // Short PIN rejected, PIN entry retried.
      e0 = err_seen;
      enter4(1234);
      press(4'd5);
      press(4'hA);
      idle(2);
      chk("spin_errs", 32'(err_seen - e0), 1);
      exp_q.push_back(cred_t'{12'd1234, 14'd4321});
      enter4(4321);
      chk("spin_cred", 32'(cred_valid), 1);
      auth(1'b1);
      chk("spin_sess", 32'(session_active), 1);
      end_sess();

      // Consecutive auth failures.
      for (int i = 0; i < 3; i++) begin
         creds(1111 + i, 2222);
         chk("fail_cred", 32'(cred_valid), 1);
         auth(1'b0);
         chk("fail_err", 32'(error), 1);
         chk("fail_acct", 32'(account_num), 0);
         chk("fail_pin", 32'(pin), 0);
         chk("fail_cdrop", 32'(cred_valid), 0);
      end
`ifdef KEYPAD_LOCKOUT_EN
      chk("lock_on", 32'(locked), 1);
      for (int i = 1; i < 5000; i++) begin
         @(negedge clk);
         key_valid   = (i == 10);
         key_code    = 4'd1;
         session_end = (i == 20);
      end
      chk("lock_hold", 32'(locked), 1);
      idle(1);
      chk("lock_off", 32'(locked), 0);
      enter4(1234);
      chk("lock_acct", 32'(account_num), 1234);
      end_sess();
      creds(1000, 2000);
      auth(1'b0);
      chk("lock_reset", 32'(locked), 0);
`else
      chk("nolock_3", 32'(locked), 0);
      creds(1000, 2000);
      auth(1'b0);
      chk("nolock_4", 32'(locked), 0);
`endif
      idle(3);
      chk("queue_empty", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
